// File: rtl/gpio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpio_pkg
// Description : Shared constants for the GPIO controller: default pin count
//               and the register map addresses.
// Revision    : 1.0 - initial release
// ============================================================================
package gpio_pkg;

  localparam int DEFAULT_WIDTH = 16;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IN      = 3'd2;
  localparam logic [2:0] ADDR_RISE_EN = 3'd3;
  localparam logic [2:0] ADDR_FALL_EN = 3'd4;
  localparam logic [2:0] ADDR_PEND    = 3'd5;
  localparam logic [2:0] ADDR_SET     = 3'd6;
  localparam logic [2:0] ADDR_CLR     = 3'd7;

endpackage
`default_nettype wire

// File: rtl/gpio_sync.sv
`default_nettype none
// ============================================================================
// Module      : gpio_sync
// Description : Multi-flop synchronizer bringing asynchronous pad inputs into
//               the clk domain. SYNC_STAGES is expected to be 2..4.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_sync #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);

  // stage[0] is the metastability-catching flop, stage[SYNC_STAGES-1] the output
  logic [SYNC_STAGES-1:0][WIDTH-1:0] stage;

  // Shift the pin values one stage deeper every cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      stage <= '0;
    end else begin
      stage <= {stage[SYNC_STAGES-2:0], async_in};
    end
  end

  assign sync_out = stage[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/gpio_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : gpio_ctrl
// Description : GPIO controller with data/direction registers, set/clear
//               aliases, synchronized input sampling, per-bit rise/fall edge
//               detection with W1C pending bits and a level interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             we,
  input  logic [2:0]       addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             ack,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_dr,
  output logic [WIDTH-1:0] gpio_ts,
  output logic             irq
);

  logic [WIDTH-1:0] data_reg;
  logic [WIDTH-1:0] dir_reg;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] pend;
  logic [WIDTH-1:0] in_sync;
  logic [WIDTH-1:0] in_prev;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] pend_clr;
  logic [WIDTH-1:0] read_value;
  logic             wr_en;

  gpio_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (gpio_in),
    .sync_out (in_sync)
  );

  assign wr_en = req & we;

  // Edge events come from the registered enables, so an enable write acts next cycle
  assign edge_set = (in_sync & ~in_prev & rise_en) | (~in_sync & in_prev & fall_en);
  assign pend_clr = (wr_en && addr == ADDR_PEND) ? wdata : '0;

  // Read mux over the current (pre-edge) register contents; SET/CLR read as 0
  always_comb begin
    read_value = '0;
    case (addr)
      ADDR_DATA:    read_value = data_reg;
      ADDR_DIR:     read_value = dir_reg;
      ADDR_IN:      read_value = in_sync;
      ADDR_RISE_EN: read_value = rise_en;
      ADDR_FALL_EN: read_value = fall_en;
      ADDR_PEND:    read_value = pend;
      default:      read_value = '0;
    endcase
  end

  // Writable configuration registers; IN, PEND are handled elsewhere
  always_ff @(posedge clk) begin
    if (reset) begin
      data_reg <= '0;
      dir_reg  <= '0;
      rise_en  <= '0;
      fall_en  <= '0;
    end else if (wr_en) begin
      case (addr)
        ADDR_DATA:    data_reg <= wdata;
        ADDR_DIR:     dir_reg  <= wdata;
        ADDR_RISE_EN: rise_en  <= wdata;
        ADDR_FALL_EN: fall_en  <= wdata;
        ADDR_SET:     data_reg <= data_reg | wdata;
        ADDR_CLR:     data_reg <= data_reg & ~wdata;
        default:      ;
      endcase
    end
  end

  // One-cycle history of the synchronized inputs for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      in_prev <= '0;
    end else begin
      in_prev <= in_sync;
    end
  end

  // Pending bits: W1C clear first, then a same-cycle edge sets the bit again
  always_ff @(posedge clk) begin
    if (reset) begin
      pend <= '0;
    end else begin
      pend <= (pend & ~pend_clr) | edge_set;
    end
  end

  // Interrupt follows the pending register with one cycle of latency
  always_ff @(posedge clk) begin
    if (reset) begin
      irq <= 1'b0;
    end else begin
      irq <= |pend;
    end
  end

  // Bus response: ack one cycle after each strobe, rdata only for reads
  always_ff @(posedge clk) begin
    if (reset) begin
      ack   <= 1'b0;
      rdata <= '0;
    end else begin
      ack   <= req;
      rdata <= (req && !we) ? read_value : '0;
    end
  end

  assign gpio_dr = data_reg;
  assign gpio_ts = dir_reg;

endmodule
`default_nettype wire

// File: tb/tb_gpio_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpio_ctrl
// Description : Self-checking bench for gpio_ctrl: a per-cycle behavioural
//               model compared on every falling edge, plus directed scenarios
//               with literal expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_ctrl;
  import gpio_pkg::*;

  localparam int WIDTH = 16;
  localparam int SYNC  = 2;

  logic             clk     = 1'b0;
  logic             reset   = 1'b1;
  logic             req     = 1'b0;
  logic             we      = 1'b0;
  logic [2:0]       addr    = 3'd0;
  logic [WIDTH-1:0] wdata   = '0;
  logic [WIDTH-1:0] gpio_in = '0;
  logic [WIDTH-1:0] rdata;
  logic [WIDTH-1:0] gpio_dr;
  logic [WIDTH-1:0] gpio_ts;
  logic             ack;
  logic             irq;

  int checks    = 0;
  int errors    = 0;
  int ack_count = 0;

  always #5 clk = ~clk;

  gpio_ctrl #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .we      (we),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .ack     (ack),
    .gpio_in (gpio_in),
    .gpio_dr (gpio_dr),
    .gpio_ts (gpio_ts),
    .irq     (irq)
  );

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Register file kept as plain values; pins kept as a history of samples,
  // pin_hist[k] = gpio_in sampled k+1 edges ago.
  logic [WIDTH-1:0] m_data, m_dir, m_rise, m_fall, m_pend, m_rdata;
  logic             m_ack, m_irq;
  logic [WIDTH-1:0] pin_hist [0:SYNC];
  bit               model_live = 0;

  function automatic logic [WIDTH-1:0] model_read(input logic [2:0] a);
    case (a)
      3'd0:    return m_data;
      3'd1:    return m_dir;
      3'd2:    return pin_hist[SYNC-1];
      3'd3:    return m_rise;
      3'd4:    return m_fall;
      3'd5:    return m_pend;
      default: return '0;
    endcase
  endfunction

  always @(posedge clk) begin : model
    logic [WIDTH-1:0] now_in, last_in, events, rv;
    model_live = 1;
    if (reset) begin
      m_data = '0; m_dir = '0; m_rise = '0; m_fall = '0; m_pend = '0;
      m_rdata = '0; m_ack = 1'b0; m_irq = 1'b0;
      for (int i = 0; i <= SYNC; i++) pin_hist[i] = '0;
    end else begin
      now_in  = pin_hist[SYNC-1];
      last_in = pin_hist[SYNC];
      events  = (now_in & ~last_in & m_rise) | (~now_in & last_in & m_fall);
      rv      = model_read(addr);
      m_irq   = (m_pend != '0);
      m_ack   = req;
      m_rdata = (req && !we) ? rv : '0;
      if (req && we) begin
        case (addr)
          3'd0: m_data = wdata;
          3'd1: m_dir  = wdata;
          3'd3: m_rise = wdata;
          3'd4: m_fall = wdata;
          3'd5: m_pend = m_pend & ~wdata;
          3'd6: m_data = m_data | wdata;
          3'd7: m_data = m_data & ~wdata;
          default: ;
        endcase
      end
      m_pend = m_pend | events;
      for (int i = SYNC; i > 0; i--) pin_hist[i] = pin_hist[i-1];
      pin_hist[0] = gpio_in;
    end
  end

  // Compare every cycle, half a period away from the active edge
  always @(negedge clk) begin
    if (model_live) begin
      check("m_gpio_dr", gpio_dr, m_data);
      check("m_gpio_ts", gpio_ts, m_dir);
      check("m_irq", WIDTH'(irq), WIDTH'(m_irq));
      check("m_ack", WIDTH'(ack), WIDTH'(m_ack));
      check("m_rdata", rdata, m_rdata);
    end
  end

  // ---------------- stimulus helpers (called #1 after a rising edge) --------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic access(input logic w, input logic [2:0] a, input logic [WIDTH-1:0] d,
                        output logic [WIDTH-1:0] rv, output logic ak);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk);
    #1;
    req = 1'b0; we = 1'b0;
    rv = rdata;
    ak = ack;
  endtask

  task automatic wr(input logic [2:0] a, input logic [WIDTH-1:0] d, input string name);
    logic [WIDTH-1:0] v;
    logic k;
    access(1'b1, a, d, v, k);
    check({name, "_ack"}, WIDTH'(k), WIDTH'(1));
    check({name, "_rdata0"}, v, '0);
  endtask

  task automatic rd(input logic [2:0] a, input logic [WIDTH-1:0] exp, input string name);
    logic [WIDTH-1:0] v;
    logic k;
    access(1'b0, a, '0, v, k);
    check({name, "_ack"}, WIDTH'(k), WIDTH'(1));
    check(name, v, exp);
    if (k) ack_count++;
  endtask

  localparam logic [WIDTH-1:0] S6_EXP [8] = '{16'h1234, 16'h5678, 16'h0F00, 16'h0003,
                                               16'h8001, 16'h0000, 16'h0000, 16'h0000};

  initial begin
    // Reset state
    tick(3);
    check("rst_gpio_dr", gpio_dr, '0);
    check("rst_gpio_ts", gpio_ts, '0);
    check("rst_irq", WIDTH'(irq), '0);
    check("rst_ack", WIDTH'(ack), '0);
    check("rst_rdata", rdata, '0);
    reset = 1'b0;
    tick(1);

    // Scenario 1: direction and data writes
    wr(ADDR_DIR, 16'h00FF, "s1_dir");
    check("s1_ts", gpio_ts, 16'h00FF);
    wr(ADDR_DATA, 16'hA5A5, "s1_data");
    check("s1_dr", gpio_dr, 16'hA5A5);
    check("s1_ts2", gpio_ts, 16'h00FF);

    // Scenario 2: SET / CLR aliases, read-zero aliases, IN write ignored
    wr(ADDR_DATA, 16'h00F0, "s2_data");
    wr(ADDR_SET, 16'h000F, "s2_set");
    rd(ADDR_DATA, 16'h00FF, "s2_rd_after_set");
    wr(ADDR_CLR, 16'h0081, "s2_clr");
    rd(ADDR_DATA, 16'h007E, "s2_rd_after_clr");
    rd(ADDR_SET, 16'h0000, "s2_rd_set");
    rd(ADDR_CLR, 16'h0000, "s2_rd_clr");
    wr(ADDR_IN, 16'hFFFF, "s2_wr_in");
    rd(ADDR_IN, 16'h0000, "s2_rd_in");
    check("s2_dr", gpio_dr, 16'h007E);

    // Scenario 3: rising edge latency (pin -> IN in 2 cycles, PEND one later)
    wr(ADDR_RISE_EN, 16'h0001, "s3_rise_en");
    gpio_in = 16'h0001;
    tick(2);
    rd(ADDR_PEND, 16'h0000, "s3_pend_same_edge");
    check("s3_irq_low", WIDTH'(irq), '0);
    rd(ADDR_PEND, 16'h0001, "s3_pend_set");
    check("s3_irq_high", WIDTH'(irq), WIDTH'(1));

    // Scenario 4: edge and W1C on the same bit in the same cycle
    gpio_in = 16'h0000;
    tick(4);
    wr(ADDR_PEND, 16'h0001, "s4_w1c_pre");
    tick(2);
    check("s4_irq_cleared", WIDTH'(irq), '0);
    gpio_in = 16'h0001;
    tick(2);
    wr(ADDR_PEND, 16'h0001, "s4_w1c_collide");
    rd(ADDR_PEND, 16'h0001, "s4_pend_kept");
    wr(ADDR_RISE_EN, 16'h0000, "s4_rise_off");
    rd(ADDR_PEND, 16'h0001, "s4_pend_after_en_clr");
    wr(ADDR_PEND, 16'h0001, "s4_w1c");
    rd(ADDR_PEND, 16'h0000, "s4_pend_clear");
    check("s4_irq_low", WIDTH'(irq), '0);

    // Scenario 5: falling edge interrupted by reset with a concurrent request
    gpio_in = 16'h8000;
    tick(4);
    wr(ADDR_FALL_EN, 16'h8000, "s5_fall_en");
    gpio_in = 16'h0000;
    tick(1);
    reset = 1'b1; req = 1'b1; we = 1'b1; addr = ADDR_DATA; wdata = 16'hFFFF;
    tick(1);
    check("s5_rst_dr", gpio_dr, '0);
    check("s5_rst_ts", gpio_ts, '0);
    check("s5_rst_irq", WIDTH'(irq), '0);
    check("s5_rst_ack", WIDTH'(ack), '0);
    tick(1);
    reset = 1'b0; req = 1'b0; we = 1'b0;
    tick(1);
    check("s5_no_ack", WIDTH'(ack), '0);
    check("s5_dr_after", gpio_dr, '0);
    rd(ADDR_PEND, 16'h0000, "s5_pend");
    rd(ADDR_FALL_EN, 16'h0000, "s5_fall_en_rst");

    // Scenario 6: back-to-back reads of the whole map
    gpio_in = 16'h0F00;
    tick(5);
    wr(ADDR_DATA, 16'h1234, "s6_data");
    wr(ADDR_DIR, 16'h5678, "s6_dir");
    wr(ADDR_RISE_EN, 16'h0003, "s6_rise");
    wr(ADDR_FALL_EN, 16'h8001, "s6_fall");
    ack_count = 0;
    for (int i = 0; i < 8; i++) begin
      rd(3'(i), S6_EXP[i], $sformatf("s6_rd%0d", i));
    end
    check("s6_ack_count", WIDTH'(ack_count), WIDTH'(8));
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
